// File: rtl/keypad_scanner_if.sv
// Keypad pins and decoded-digit outputs of keypad_scanner.
// master: the scanner side; slave: the keypad/display side.
interface keypad_scanner_if;
   logic [3:0] rows;
   logic [3:0] cols;
   logic [3:0] s1;
   logic [3:0] s2;
   logic       new_key;

   modport master (input rows, output cols, s1, s2, new_key);
   modport slave  (output rows, input cols, s1, s2, new_key);
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with press/release debounce and a two-digit history.
// Optional KEYPAD_SYNC_EN: two-flop synchronizer on the row inputs.
module keypad_scanner #(
   parameter int SCAN_DIV        = 4800,
   parameter int DEBOUNCE_CYCLES = 960000
) (
   input logic              clk,
   input logic              reset,
   keypad_scanner_if.master kp
);
   localparam int DW = $clog2(SCAN_DIV);
   localparam int CW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {SCAN, DEB_PRESS, HELD, DEB_RELEASE} state_t;

   state_t        state_q;
   logic [1:0]    k_q;
   logic [1:0]    row_q;
   logic [DW-1:0] div_q;
   logic [CW-1:0] cnt_q;
   logic [3:0]    cols_q;
   logic [3:0]    s1_q;
   logic [3:0]    s2_q;
   logic          new_key_q;
   logic [3:0]    rows_s;
   logic [1:0]    low_row;
   logic          any_low;
   logic          row_hi;

`ifdef KEYPAD_SYNC_EN
   logic [3:0] sync1_q;
   logic [3:0] sync2_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q <= 4'hF;
         sync2_q <= 4'hF;
      end else begin
         sync1_q <= kp.rows;
         sync2_q <= sync1_q;
      end
   end
   assign rows_s = sync2_q;
`else
   assign rows_s = kp.rows;
`endif

   // Lowest-index low row wins when several rows are pulled at once.
   always_comb begin
      low_row = 2'd3;
      if (!rows_s[0])      low_row = 2'd0;
      else if (!rows_s[1]) low_row = 2'd1;
      else if (!rows_s[2]) low_row = 2'd2;
   end

   assign any_low = ~&rows_s;
   assign row_hi  = rows_s[row_q];

   function automatic logic [3:0] col_drive(input logic [1:0] k);
      return ~(4'b0001 << k);
   endfunction

   function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
      logic [3:0] code;
      case ({r, c})
         4'h0: code = 4'h1;  4'h1: code = 4'h2;  4'h2: code = 4'h3;  4'h3: code = 4'hA;
         4'h4: code = 4'h4;  4'h5: code = 4'h5;  4'h6: code = 4'h6;  4'h7: code = 4'hB;
         4'h8: code = 4'h7;  4'h9: code = 4'h8;  4'hA: code = 4'h9;  4'hB: code = 4'hC;
         4'hC: code = 4'hE;  4'hD: code = 4'h0;  4'hE: code = 4'hF;  default: code = 4'hD;
      endcase
      return code;
   endfunction

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= SCAN;
         k_q       <= 2'd0;
         row_q     <= 2'd0;
         div_q     <= '0;
         cnt_q     <= '0;
         cols_q    <= 4'b1110;
         s1_q      <= 4'h0;
         s2_q      <= 4'h0;
         new_key_q <= 1'b0;
      end else begin
         new_key_q <= 1'b0;
         case (state_q)
            SCAN: begin
               if (div_q == DIV_LAST) begin
                  div_q <= '0;
                  if (any_low) begin
                     // Column stays put so the debounce watches the same key.
                     row_q   <= low_row;
                     cnt_q   <= '0;
                     state_q <= DEB_PRESS;
                  end else begin
                     k_q    <= k_q + 2'd1;
                     cols_q <= col_drive(k_q + 2'd1);
                  end
               end else begin
                  div_q <= div_q + 1'b1;
               end
            end
            DEB_PRESS: begin
               if (row_hi) begin
                  state_q <= SCAN;
                  div_q   <= '0;
                  k_q     <= k_q + 2'd1;
                  cols_q  <= col_drive(k_q + 2'd1);
               end else if (cnt_q == DEB_LAST) begin
                  s1_q      <= s2_q;
                  s2_q      <= key_code(row_q, k_q);
                  new_key_q <= 1'b1;
                  state_q   <= HELD;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            HELD: begin
               if (row_hi) begin
                  cnt_q   <= '0;
                  state_q <= DEB_RELEASE;
               end
            end
            DEB_RELEASE: begin
               if (!row_hi) begin
                  state_q <= HELD;
               end else if (cnt_q == DEB_LAST) begin
                  state_q <= SCAN;
                  div_q   <= '0;
                  k_q     <= k_q + 2'd1;
                  cols_q  <= col_drive(k_q + 2'd1);
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: state_q <= SCAN;
         endcase
      end
   end

   assign kp.cols    = cols_q;
   assign kp.s1      = s1_q;
   assign kp.s2      = s2_q;
   assign kp.new_key = new_key_q;
endmodule

// File: tb/tb_keypad_scanner.sv
// Directed + random bench for keypad_scanner against a key-matrix model.
module tb_keypad_scanner;
   localparam int SD = 4;
   localparam int DB = 8;
`ifdef KEYPAD_SYNC_EN
   localparam int SYNC_LAT = 2;
`else
   localparam int SYNC_LAT = 0;
`endif

   logic clk = 1'b0;
   logic reset = 1'b1;
   keypad_scanner_if kp();

   keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_CYCLES(DB)) dut (
      .clk(clk), .reset(reset), .kp(kp)
   );

   always #5 clk = ~clk;

   // Physical key matrix: a closed key shorts its row to its column.
   bit         pressed [4][4];
   logic [3:0] force_low = 4'h0;
   logic [3:0] rv;
   always_comb begin
      rv = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (pressed[r][c] && !kp.cols[c]) rv[r] = 1'b0;
      rv = rv & ~force_low;
   end
   assign kp.rows = rv;

   logic [3:0] kmap [4][4] = '{'{4'h1, 4'h2, 4'h3, 4'hA},
                               '{4'h4, 4'h5, 4'h6, 4'hB},
                               '{4'h7, 4'h8, 4'h9, 4'hC},
                               '{4'hE, 4'h0, 4'hF, 4'hD}};

   int total = 0;
   int bad = 0;
   int pulses = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Per-cycle invariants and pulse counting.
   logic rst_edge = 1'b1;
   initial forever begin
      @(posedge clk);
      rst_edge = reset;
   end

   initial begin
      logic       prev_nk;
      logic [3:0] ps1, ps2;
      prev_nk = 1'b0; ps1 = 4'h0; ps2 = 4'h0;
      forever begin
         @(negedge clk);
         if (kp.new_key === 1'b1) pulses++;
         check("cols_one_low", $countones(~kp.cols), 1);
         if (!rst_edge) begin
            check("nk_twice", {31'd0, prev_nk & kp.new_key}, 0);
            check("s_changed_wo_nk",
                  {31'd0, (kp.new_key !== 1'b1) && (kp.s1 !== ps1 || kp.s2 !== ps2)}, 0);
         end
         prev_nk = kp.new_key; ps1 = kp.s1; ps2 = kp.s2;
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic release_all();
      pressed = '{default: 1'b0};
   endtask

   // Align to the first cycle of the slot that drives 'want'.
   task automatic wait_slot_start(input logic [3:0] want);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 40 && kp.cols === want; i++) @(negedge clk);
      for (int i = 0; i < 40; i++) begin
         if (kp.cols === want) begin ok = 1'b1; break; end
         @(negedge clk);
      end
      check("slot_align", {31'd0, ok}, 1);
   endtask

   task automatic first_change(input logic [3:0] from, output logic [3:0] to, output int lat);
      to = from; lat = -1;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (kp.cols !== from) begin to = kp.cols; lat = i + 1; return; end
      end
   endtask

   initial begin
      int         p0, lat;
      logic [3:0] to, e;
      logic [3:0] m_s1, m_s2;
      int         m_p;
      bit         frozen;
      release_all();

      // Reset and free-running scan
      reset = 1'b1;
      cyc(2);
      check("rst_cols", kp.cols, 4'b1110);
      check("rst_s1", kp.s1, 0);
      check("rst_s2", kp.s2, 0);
      check("rst_nk", kp.new_key, 0);
      reset = 1'b0;
      for (int n = 1; n <= 16; n++) begin
         @(negedge clk);
         e = ~(4'b0001 << ((n / SD) % 4));
         check("scan_step", kp.cols, e);
      end

      // Key 6 then key A
      p0 = pulses;
      pressed[1][2] = 1'b1; cyc(60);
      check("k6_pulses", pulses - p0, 1);
      check("k6_s1", kp.s1, 4'h0);
      check("k6_s2", kp.s2, 4'h6);
      release_all(); cyc(30);
      p0 = pulses;
      pressed[0][3] = 1'b1; cyc(60);
      check("kA_pulses", pulses - p0, 1);
      check("kA_s1", kp.s1, 4'h6);
      check("kA_s2", kp.s2, 4'hA);
      release_all(); cyc(30);

      // Short press of key 5 is rejected, scan resumes at c2
      wait_slot_start(4'b1101);
      p0 = pulses;
      pressed[1][1] = 1'b1; cyc(5);
      check("short_frozen", kp.cols, 4'b1101);
      release_all();
      first_change(4'b1101, to, lat);
      check("short_resume_col", to, 4'b1011);
      check("short_resume_lat", lat, 1 + SYNC_LAT);
      cyc(10);
      check("short_pulses", pulses - p0, 0);
      check("short_s1", kp.s1, 4'h6);
      check("short_s2", kp.s2, 4'hA);

      // Long hold of key 5 with a stray row mid-hold
      p0 = pulses;
      frozen = 1'b1;
      pressed[1][1] = 1'b1;
      for (int i = 0; i < 100; i++) begin
         if (i == 50) force_low = 4'b0100;
         if (i == 60) force_low = 4'h0;
         @(negedge clk);
         if (i >= 40 && kp.cols !== 4'b1101) frozen = 1'b0;
      end
      check("hold_frozen", {31'd0, frozen}, 1);
      check("hold_pulses", pulses - p0, 1);
      check("hold_s1", kp.s1, 4'hA);
      check("hold_s2", kp.s2, 4'h5);

      // Release bounce: 3 high, re-press, then true release
      p0 = pulses;
      release_all(); cyc(3);
      pressed[1][1] = 1'b1; cyc(20);
      check("bounce_still_held", kp.cols, 4'b1101);
      release_all();
      first_change(4'b1101, to, lat);
      check("rel_resume_col", to, 4'b1011);
      check("rel_resume_lat", lat, DB + 1 + SYNC_LAT);
      cyc(10);
      check("bounce_pulses", pulses - p0, 0);

      // Reset during the 4th debounce cycle of a press
      wait_slot_start(4'b1011);
      p0 = pulses;
      pressed[2][2] = 1'b1; cyc(7);
      check("abort_in_deb", kp.cols, 4'b1011);
      reset = 1'b1; release_all();
      cyc(2);
      check("abort_nk", kp.new_key, 0);
      check("abort_s1", kp.s1, 0);
      check("abort_s2", kp.s2, 0);
      check("abort_cols", kp.cols, 4'b1110);
      reset = 1'b0;
      cyc(30);
      check("abort_pulses", pulses - p0, 0);
      check("abort_s2_after", kp.s2, 0);

      // Press latency from the start of the key's column slot
      wait_slot_start(4'b1011);
      pressed[2][2] = 1'b1;
      lat = -1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (kp.new_key === 1'b1) begin lat = i + 1; break; end
      end
      check("press_lat", lat, SD + DB);
      check("k9_s2", kp.s2, 4'h9);
      release_all(); cyc(30);

      // Random presses against the digit-history model
      m_s1 = 4'h0; m_s2 = 4'h9;
      for (int t = 0; t < 16; t++) begin
         int r, c;
         bit lng;
         r = $urandom_range(0, 3);
         c = $urandom_range(0, 3);
         lng = 1'($urandom_range(0, 1));
         p0 = pulses;
         m_p = 0;
         pressed[r][c] = 1'b1;
         if (lng) begin
            cyc(40);
            m_s1 = m_s2; m_s2 = kmap[r][c]; m_p = 1;
         end else begin
            cyc($urandom_range(1, DB - 1));
         end
         release_all(); cyc(30);
         check("rnd_pulses", pulses - p0, m_p);
         check("rnd_s1", kp.s1, m_s1);
         check("rnd_s2", kp.s2, m_s2);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
